// File: rtl/accu_rr_sched_pkg.sv
// Shared types and helpers for the round-robin accumulation scheduler.
package accu_rr_sched_pkg;

    // Upper bound on channel count; the arbitration helper is sized for it.
    localparam int MAX_CH     = 8;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_GROUP  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOCK = 2'd1,
        OUT  = 2'd2
    } state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First asserted request at or after ptr, wrapping within n channels.
    function automatic pick_t rr_pick(input logic [MAX_CH-1:0] vld,
                                      input int ptr,
                                      input int n);
        pick_t r;
        int    c;
        r.found = 1'b0;
        r.idx   = '0;
        for (int k = 0; k < MAX_CH; k++) begin
            c = (ptr + k) % n;
            if ((k < n) && !r.found && vld[c]) begin
                r.found = 1'b1;
                r.idx   = c[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/accu_rr_sched_if.sv
// Producer/consumer bus for the scheduler: per-channel beats in, tagged sums out.
interface accu_rr_sched_if
    import accu_rr_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int OUT_W  = DEF_DATA_W + $clog2(DEF_GROUP),
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) ();

    logic [NUM_CH-1:0]        valid_a;
    logic [NUM_CH*DATA_W-1:0] data_in;
    logic [NUM_CH-1:0]        ready_a;
    logic                     valid_b;
    logic                     ready_b;
    logic [OUT_W-1:0]         data_out;
    logic [CH_W-1:0]          ch_out;
    logic                     busy;

    // Scheduler side.
    modport slave (
        input  valid_a, data_in, ready_b,
        output ready_a, valid_b, data_out, ch_out, busy
    );

    // Producers and consumer side.
    modport master (
        output valid_a, data_in, ready_b,
        input  ready_a, valid_b, data_out, ch_out, busy
    );

endinterface

// File: rtl/accu_rr_sched_group_core.sv
// Accumulation datapath: running sum, beat counter and the held group result.
module accu_rr_sched_group_core
    import accu_rr_sched_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int GROUP  = DEF_GROUP,
    parameter int OUT_W  = DATA_W + $clog2(GROUP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat_fire_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] sel_data_i,
    output logic              last_beat_o,
    output logic [OUT_W-1:0]  result_o
);

    localparam int              CNT_W = $clog2(GROUP);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(GROUP - 1);

    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] base;
    logic [OUT_W-1:0] sum;

    // clear_i marks the first beat of a group: it starts a fresh sum.
    assign base        = clear_i ? '0 : acc_q;
    assign sum         = base + OUT_W'(sel_data_i);
    assign last_beat_o = beat_fire_i && !clear_i && (cnt_q == LAST);
    assign result_o    = res_q;

    // Next-state: accumulate each beat; the final beat moves the sum to the result.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        res_d = res_q;
        if (beat_fire_i) begin
            if (last_beat_o) begin
                res_d = sum;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = clear_i ? CNT_W'(1) : cnt_q + 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            res_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            res_q <= res_d;
        end
    end

endmodule

// File: rtl/accu_rr_sched.sv
// Round-robin scheduler granting one channel per accumulation group.
module accu_rr_sched
    import accu_rr_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int GROUP  = DEF_GROUP,
    parameter int OUT_W  = DATA_W + $clog2(GROUP),
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    accu_rr_sched_if.slave        bus
);

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ptr_q, grant_q, ch_q;
    logic              valid_b_q;
    logic [CH_W-1:0]   sel;
    logic [NUM_CH-1:0] ready;
    logic [DATA_W-1:0] sel_data;
    logic [OUT_W-1:0]  result;
    logic              beat_fire, last_beat, out_fire;
    pick_t             pick;

    assign pick      = rr_pick(MAX_CH'(bus.valid_a), int'(ptr_q), NUM_CH);
    // In IDLE the candidate is the arbitration winner; afterwards the locked channel.
    assign sel       = (state_q == IDLE) ? CH_W'(pick.idx) : grant_q;
    assign sel_data  = bus.data_in[int'(sel)*DATA_W +: DATA_W];
    assign beat_fire = |(bus.valid_a & ready);
    assign out_fire  = valid_b_q & bus.ready_b;

    accu_rr_sched_group_core #(
        .DATA_W (DATA_W),
        .GROUP  (GROUP),
        .OUT_W  (OUT_W)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .beat_fire_i (beat_fire),
        .clear_i     (state_q == IDLE),
        .sel_data_i  (sel_data),
        .last_beat_o (last_beat),
        .result_o    (result)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: first beat locks the grant, last beat presents the sum.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (beat_fire) state_d = LOCK;
            LOCK:    if (last_beat) state_d = OUT;
            OUT:     if (out_fire)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: ready only toward the winner (IDLE) or the locked channel.
    always_comb begin
        ready = '0;
        unique case (state_q)
            IDLE:    if (pick.found) ready[sel] = 1'b1;
            LOCK:    ready[grant_q] = 1'b1;
            default: ready = '0;
        endcase
    end

    // Grant, round-robin pointer and result handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            grant_q   <= '0;
            ch_q      <= '0;
            valid_b_q <= 1'b0;
        end else begin
            if ((state_q == IDLE) && beat_fire) grant_q <= sel;
            if ((state_q == LOCK) && last_beat) begin
                valid_b_q <= 1'b1;
                ch_q      <= grant_q;
                ptr_q     <= (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
            end else if (out_fire) begin
                valid_b_q <= 1'b0;
            end
        end
    end

    assign bus.ready_a  = ready;
    assign bus.valid_b  = valid_b_q;
    assign bus.data_out = result;
    assign bus.ch_out   = ch_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_accu_rr_sched.sv
// Bench for accu_rr_sched: directed scenarios plus randomized traffic against a group-level model.
module tb_accu_rr_sched;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int G  = 4;
    localparam int OW = DW + $clog2(G);
    localparam int CW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    accu_rr_sched_if #(.NUM_CH(N), .DATA_W(DW), .OUT_W(OW), .CH_W(CW)) bus ();

    accu_rr_sched #(.NUM_CH(N), .DATA_W(DW), .GROUP(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Producer beat queues and stimulus controls.
    int       q[N][$];
    logic [N-1:0] hold = '0;
    logic     rdyb = 1'b1;

    // Group-level reference model.
    int  m_lock, m_cnt, m_sum, m_ptr;
    bit  m_pend;
    int  e_data, e_ch;
    int  log_ch[$], log_sum[$];
    int  out_cyc;
    logic [N-1:0] obs_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lock = -1; m_cnt = 0; m_sum = 0; m_ptr = 0; m_pend = 0;
        for (int i = 0; i < N; i++) q[i].delete();
        hold = '0;
    endtask

    function automatic bit all_done();
        bit d;
        d = !m_pend && (m_lock < 0);
        for (int i = 0; i < N; i++) if (q[i].size() != 0) d = 0;
        return d;
    endfunction

    // One clock cycle: drive at negedge, check settled outputs, update the model, advance.
    task automatic tick();
        logic [N-1:0] v, er, fire;
        int c;
        for (int i = 0; i < N; i++) begin
            v[i] = (q[i].size() > 0) && !hold[i];
            bus.data_in[i*DW +: DW] = v[i] ? DW'(q[i][0]) : DW'($urandom);
        end
        bus.valid_a = v;
        bus.ready_b = rdyb;
        #1;
        obs_ready = bus.ready_a;
        er = '0;
        if (m_pend) er = '0;
        else if (m_lock >= 0) er[m_lock] = 1'b1;
        else begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (v[c]) begin
                    er[c] = 1'b1;
                    break;
                end
            end
        end
        chk("ready_a", 32'(bus.ready_a), 32'(er));
        chk("ready_onehot0", 32'($onehot0(bus.ready_a)), 32'd1);
        chk("valid_b", 32'(bus.valid_b), 32'(m_pend));
        chk("busy", 32'(bus.busy), 32'(m_pend || (m_lock >= 0)));
        if (m_pend) begin
            chk("data_out", 32'(bus.data_out), e_data);
            chk("ch_out", 32'(bus.ch_out), e_ch);
        end
        if (bus.valid_b && rdyb) begin
            log_ch.push_back(int'(bus.ch_out));
            log_sum.push_back(int'(bus.data_out));
            out_cyc = cyc;
            m_pend  = 0;
        end
        fire = v & bus.ready_a;
        for (int i = 0; i < N; i++) begin
            if (fire[i]) begin
                if (m_lock < 0) m_lock = i;
                m_sum += q[i][0];
                m_cnt++;
                void'(q[i].pop_front());
                if (m_cnt == G) begin
                    m_pend = 1; e_data = m_sum; e_ch = i;
                    m_ptr  = (i + 1) % N;
                    m_lock = -1; m_cnt = 0; m_sum = 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_done(input int max);
        int n = 0;
        while (!all_done() && n < max) begin
            tick();
            n++;
        end
        if (!all_done()) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    // Asynchronous reset pulse away from the clock edge.
    task automatic do_reset();
        bus.valid_a = '0;
        bus.ready_b = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_valid_b", 32'(bus.valid_b), 32'd0);
        chk("rst_data_out", 32'(bus.data_out), 32'd0);
        chk("rst_ch_out", 32'(bus.ch_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ready_a", 32'(bus.ready_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_log(input string tag, input int n,
                             input int ch0, input int s0, input int ch1, input int s1,
                             input int ch2, input int s2);
        chk({tag, "_count"}, log_ch.size(), n);
        if (n > 0) begin chk({tag, "_ch0"}, log_ch[0], ch0); chk({tag, "_sum0"}, log_sum[0], s0); end
        if (n > 1) begin chk({tag, "_ch1"}, log_ch[1], ch1); chk({tag, "_sum1"}, log_sum[1], s1); end
        if (n > 2) begin chk({tag, "_ch2"}, log_ch[2], ch2); chk({tag, "_sum2"}, log_sum[2], s2); end
        log_ch.delete();
        log_sum.delete();
    endtask

    initial begin
        int t0;
        int w;
        bus.valid_a = '0;
        bus.data_in = '0;
        bus.ready_b = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single channel, back-to-back beats.
        rdyb = 1'b1;
        q[1] = '{10, 20, 30, 40};
        t0 = cyc;
        run_done(40);
        chk("t1_latency", out_cyc - t0, 4);
        check_log("t1", 1, 1, 100, 0, 0, 0, 0);
        tick();
        chk("t1_busy_low", 32'(bus.busy), 32'd0);

        // Maximum and zero sums.
        q[0] = '{255, 255, 255, 255};
        run_done(40);
        q[0] = '{0, 0, 0, 0};
        run_done(40);
        check_log("t2", 2, 0, 1020, 0, 0, 0, 0);

        // Round robin across all channels.
        do_reset();
        rdyb = 1'b1;
        for (int i = 0; i < N; i++)
            for (int b = 1; b <= G; b++) q[i].push_back(b + i);
        for (int b = 1; b <= G; b++) q[0].push_back(b);
        run_done(60);
        chk("t3_count", log_ch.size(), 5);
        for (int k = 0; k < 5; k++) begin
            chk("t3_order", log_ch[k], k % N);
            chk("t3_sum", log_sum[k], 10 + 4 * (k % N));
        end
        log_ch.delete();
        log_sum.delete();

        // Locked grant survives a stall while others request.
        q[2] = '{5, 5, 5, 5};
        tick();
        tick();
        hold[2] = 1'b1;
        q[0] = '{3, 3, 3, 3};
        q[3] = '{9, 9, 9, 9};
        repeat (3) begin
            tick();
            chk("t4_no_ready_others", 32'(obs_ready[0] | obs_ready[3]), 32'd0);
        end
        hold = '0;
        run_done(60);
        check_log("t4", 3, 2, 20, 3, 36, 0, 12);

        // Output backpressure.
        rdyb = 1'b0;
        q[3] = '{25, 25, 25, 25};
        w = 0;
        while (!bus.valid_b && w < 20) begin tick(); w++; end
        chk("t5_valid_seen", 32'(bus.valid_b), 32'd1);
        q[1] = '{1, 2, 3, 4};
        repeat (6) begin
            tick();
            chk("t5_hold_data", 32'(bus.data_out), 32'd100);
            chk("t5_hold_ch", 32'(bus.ch_out), 32'd3);
            chk("t5_ready_zero", 32'(obs_ready), 32'd0);
        end
        rdyb = 1'b1;
        tick();
        chk("t5_xfer_ready", 32'(obs_ready), 32'd0);
        chk("t5_idle_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("t5_next_grant", 32'(obs_ready), 32'b0010);
        run_done(40);
        check_log("t5", 2, 3, 100, 1, 10, 0, 0);

        // Reset in the middle of a group.
        q[1] = '{7, 7, 7, 7};
        tick();
        tick();
        do_reset();
        rdyb = 1'b1;
        q[1] = '{1, 1, 1, 1};
        q[3] = '{2, 2, 2, 2};
        run_done(40);
        check_log("t6", 2, 1, 4, 3, 8, 0, 0);

        // Randomized traffic, holds and backpressure.
        repeat (1500) begin
            for (int i = 0; i < N; i++) begin
                if (q[i].size() == 0 && $urandom_range(0, 3) == 0)
                    for (int b = 0; b < G; b++) q[i].push_back(int'($urandom_range(0, 255)));
                hold[i] = ($urandom_range(0, 4) == 0);
            end
            rdyb = ($urandom_range(0, 3) != 0);
            tick();
        end
        hold = '0;
        rdyb = 1'b1;
        run_done(400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
